alu_cmd_issuer: RTL and testbench

//  Initiator side of the ALU opcode interface: accepts {opcode, A, B} commands over valid/ready,

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_cmd_issuer_cmd_fifo.sv | 68 ++++++
 rtl/alu_cmd_issuer.sv | 174 +++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer.
//  - Default operand/opcode widths.
//  - ALU opcode encodings (OP_ADD .. OP_CSR, plus the two illegal codes).
//  - Issuer FSM state encoding.
package alu_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_OP_W   = 4;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_MUL   = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_XOR   = 4'b0110;
  localparam logic [3:0] OP_NOT   = 4'b0111;
  localparam logic [3:0] OP_SHL   = 4'b1000;
  localparam logic [3:0] OP_SHR   = 4'b1001;
  localparam logic [3:0] OP_ROL   = 4'b1010;
  localparam logic [3:0] OP_ROR   = 4'b1011;
  localparam logic [3:0] OP_CMP   = 4'b1100;
  localparam logic [3:0] OP_CSR   = 4'b1101;
  localparam logic [3:0] OP_ILL_E = 4'b1110;
  localparam logic [3:0] OP_ILL_F = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cmd_issuer_cmd_fifo.sv
// cmd_fifo: synchronous FIFO buffering issuer commands.
// Ports:
//  clk, rst_n        clock, asynchronous active-low reset (pointers/count only)
//  push, wr_data     write request and data (ignored when full)
//  pop, rd_data      read request (ignored when empty); rd_data shows the head
//                    entry combinationally so a pop can consume it in the same cycle
//  full, empty,count occupancy status
module cmd_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;

endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: initiator side of the ALU opcode interface.
// Buffers {opcode, A, B} commands, drives a combinational ALU with registered
// operands, waits SETTLE_CYCLES, captures result/carry (with forced values for
// divide-by-zero and illegal opcodes) and returns a response over valid/ready.
// Ports:
//  clk, rst_n                          clock, asynchronous active-low reset
//  cmd_valid/cmd_ready                 command handshake
//  cmd_opcode, cmd_a, cmd_b            command payload
//  alu_opcode, alu_a, alu_b            registered ALU inputs
//  alu_result, alu_carry               ALU outputs
//  rsp_valid/rsp_ready                 response handshake
//  rsp_result, rsp_carry, rsp_zero,
//  rsp_error                           response payload
//  busy                                work in flight or buffered
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int OP_W          = DEF_OP_W,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_opcode,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic              rsp_error,
  output logic              busy
);

  localparam int FW = OP_W + 2 * DATA_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [FW-1:0]     push_word;
  logic [FW-1:0]     pop_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              fifo_push;
  logic              fifo_pop;

  state_t            state_reg;
  logic [SW-1:0]     settle_cnt_reg;
  logic              accept_en_reg;
  logic [OP_W-1:0]   alu_opcode_reg;
  logic [DATA_W-1:0] alu_a_reg;
  logic [DATA_W-1:0] alu_b_reg;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_result_reg;
  logic              rsp_carry_reg;
  logic              rsp_zero_reg;
  logic              rsp_error_reg;

  logic [DATA_W-1:0] cap_result;
  logic              cap_carry;
  logic              cap_error;

  // accept_en_reg keeps cmd_ready low while in reset and rises on the
  // first clock after release.
  assign cmd_ready = accept_en_reg & ~fifo_full;
  assign fifo_push = cmd_valid & cmd_ready;
  assign fifo_pop  = (state_reg == ST_IDLE) & ~fifo_empty;
  assign push_word = {cmd_opcode, cmd_a, cmd_b};

  cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .wr_data (push_word),
    .pop     (fifo_pop),
    .rd_data (pop_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Response values derived from the operands currently held on the ALU.
  always_comb begin
    cap_result = alu_result;
    cap_error  = 1'b0;
    cap_carry  = 1'b0;
    if ((alu_opcode_reg == OP_W'(OP_DIV)) && (alu_b_reg == '0)) begin
      cap_result = '1;
      cap_error  = 1'b1;
    end else if ((alu_opcode_reg == OP_W'(OP_ILL_E)) ||
                 (alu_opcode_reg == OP_W'(OP_ILL_F))) begin
      cap_result = '0;
      cap_error  = 1'b1;
    end
    if ((alu_opcode_reg == OP_W'(OP_ADD)) || (alu_opcode_reg == OP_W'(OP_SUB))) begin
      cap_carry = alu_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      settle_cnt_reg <= '0;
      accept_en_reg  <= 1'b0;
      alu_opcode_reg <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_result_reg <= '0;
      rsp_carry_reg  <= 1'b0;
      rsp_zero_reg   <= 1'b0;
      rsp_error_reg  <= 1'b0;
    end else begin
      accept_en_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            alu_opcode_reg <= pop_word[FW-1 -: OP_W];
            alu_a_reg      <= pop_word[2*DATA_W-1 -: DATA_W];
            alu_b_reg      <= pop_word[DATA_W-1:0];
            settle_cnt_reg <= SW'(SETTLE_CYCLES - 1);
            state_reg      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (settle_cnt_reg != '0) begin
            settle_cnt_reg <= settle_cnt_reg - SW'(1);
          end else begin
            rsp_result_reg <= cap_result;
            rsp_carry_reg  <= cap_carry;
            rsp_zero_reg   <= (cap_result == '0);
            rsp_error_reg  <= cap_error;
            rsp_valid_reg  <= 1'b1;
            state_reg      <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Payload registers are untouched here, so they stay stable
          // until the consumer takes the response.
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_opcode = alu_opcode_reg;
  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_result = rsp_result_reg;
  assign rsp_carry  = rsp_carry_reg;
  assign rsp_zero   = rsp_zero_reg;
  assign rsp_error  = rsp_error_reg;
  assign busy       = (state_reg != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Testbench for alu_cmd_issuer: behavioural ALU plus a reference model of
// the expected responses, directed vectors, back-pressure, random traffic
// and mid-operation reset.
module tb_alu_cmd_issuer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_opcode;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] alu_opcode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       rsp_error;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_cmd_issuer #(
    .DATA_W        (8),
    .OP_W          (4),
    .FIFO_DEPTH    (4),
    .SETTLE_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .rsp_error  (rsp_error),
    .busy       (busy)
  );

  // Behavioural ALU: {carry, result}. Non-ADD/SUB ops drive carry too so
  // that the issuer's carry masking is exercised.
  function automatic logic [8:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    logic [15:0] p;
    logic [8:0]  r;
    p = 16'(a) * 16'(b);
    case (op)
      4'h0:    r = 9'(a) + 9'(b);
      4'h1:    r = {a < b, a - b};
      4'h2:    r = {|p[15:8], p[7:0]};
      4'h3:    r = (b == 8'h00) ? 9'h100 : {1'b0, a / b};
      4'h4:    r = {1'b1, a & b};
      4'h5:    r = {1'b1, a | b};
      4'h6:    r = {1'b1, a ^ b};
      4'h7:    r = {1'b1, ~a};
      4'h8:    r = {a[7], a << 1};
      4'h9:    r = {a[0], a >> 1};
      default: r = {a[0], a + b + 8'd1};
    endcase
    return r;
  endfunction

  always_comb {alu_carry, alu_result} = alu_model(alu_opcode, alu_a, alu_b);

  // Expected response {result, carry, zero, error} for a command.
  function automatic logic [10:0] ref_rsp(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    logic [8:0] r;
    logic [7:0] res;
    logic       c;
    logic       err;
    r   = alu_model(op, a, b);
    res = r[7:0];
    err = 1'b0;
    if (op == 4'h3 && b == 8'h00) begin
      res = 8'hFF;
      err = 1'b1;
    end else if (op == 4'hE || op == 4'hF) begin
      res = 8'h00;
      err = 1'b1;
    end
    c = (op == 4'h0 || op == 4'h1) ? r[8] : 1'b0;
    return {res, c, (res == 8'h00), err};
  endfunction

  function automatic logic [10:0] got_rsp();
    return {rsp_result, rsp_carry, rsp_zero, rsp_error};
  endfunction

  // Drive one command from a negedge until accepted (bounded).
  task automatic send_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready === 1'b1) begin
        @(negedge clk);
        cmd_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL send_cmd_timeout got=cmd_ready_low expected=accept within 20 cycles");
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for a response, take it, return its payload.
  task automatic wait_rsp(output logic [10:0] got, output bit ok);
    ok  = 1'b0;
    got = '0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid === 1'b1) begin
        got       = got_rsp();
        ok        = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_opcode = '0;
    cmd_a      = '0;
    cmd_b      = '0;
    rsp_ready  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, busy, alu_opcode, alu_a, alu_b, got_rsp()} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b expected=all zero",
               {cmd_ready, rsp_valid, busy, alu_opcode, alu_a, alu_b, got_rsp()});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got=ready%b valid%b busy%b expected=ready1 valid0 busy0",
               cmd_ready, rsp_valid, busy);
    end
    $display("reset: done");
  endtask

  // ADD F0+20 with exact latency tracking.
  task automatic test_latency();
    rsp_ready  = 1'b0;
    cmd_valid  = 1'b1;
    cmd_opcode = 4'h0;
    cmd_a      = 8'hF0;
    cmd_b      = 8'h20;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL latency_ready got=%b expected=1", cmd_ready);
    end
    @(negedge clk);                       // edge 0 accepted the command
    cmd_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_edge0 got=%b expected=0", rsp_valid);
    end
    @(negedge clk);                       // edge 1: issued to ALU
    checks++;
    if (rsp_valid !== 1'b0 || {alu_opcode, alu_a, alu_b} !== {4'h0, 8'hF0, 8'h20}) begin
      failures++;
      $display("FAIL latency_edge1 got=valid%b alu=%h expected=valid0 alu=0f020",
               rsp_valid, {alu_opcode, alu_a, alu_b});
    end
    @(negedge clk);                       // edge 2: response captured
    checks++;
    if (rsp_valid !== 1'b1 || got_rsp() !== {8'h10, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL latency_edge2 got=valid%b rsp=%h expected=valid1 rsp=%h",
               rsp_valid, got_rsp(), {8'h10, 1'b1, 1'b0, 1'b0});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL latency_done got=valid%b busy%b expected=valid0 busy0", rsp_valid, busy);
    end
    $display("latency: ADD f0+20 rsp=%h", {rsp_result, rsp_carry, rsp_zero, rsp_error});
  endtask

  task automatic test_directed();
    logic [3:0]  ops [8];
    logic [7:0]  as  [8];
    logic [7:0]  bs  [8];
    logic [10:0] exp [8];
    logic [10:0] got;
    bit          ok;
    ops = '{4'h1, 4'h2, 4'h3, 4'hF, 4'hE, 4'h0, 4'h1, 4'h4};
    as  = '{8'h05, 8'h10, 8'h09, 8'h37, 8'h01, 8'hFF, 8'h00, 8'hFF};
    bs  = '{8'h05, 8'h10, 8'h00, 8'h42, 8'h01, 8'h01, 8'h01, 8'h0F};
    exp = '{{8'h00, 1'b0, 1'b1, 1'b0},   // SUB equal -> zero
            {8'h00, 1'b0, 1'b1, 1'b0},   // MUL overflow, carry masked
            {8'hFF, 1'b0, 1'b0, 1'b1},   // DIV by zero
            {8'h00, 1'b0, 1'b1, 1'b1},   // illegal 1111
            {8'h00, 1'b0, 1'b1, 1'b1},   // illegal 1110
            {8'h00, 1'b1, 1'b1, 1'b0},   // ADD wrap with carry
            {8'hFF, 1'b1, 1'b0, 1'b0},   // SUB borrow
            {8'h0F, 1'b0, 1'b0, 1'b0}};  // AND, carry masked
    for (int i = 0; i < 8; i++) begin
      send_cmd(ops[i], as[i], bs[i]);
      wait_rsp(got, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL directed_%0d_timeout got=no rsp expected=%h", i, exp[i]);
      end else if (got !== exp[i]) begin
        failures++;
        $display("FAIL directed_%0d got=%h expected=%h", i, got, exp[i]);
      end
      $display("directed %0d: op=%h a=%h b=%h rsp=%h", i, ops[i], as[i], bs[i], got);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp_q[$];
    logic [10:0] got;
    bit          ok;
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      op = 4'($urandom_range(0, 13));
      a  = 8'($urandom);
      b  = 8'($urandom);
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_a      = a;
      cmd_b      = b;
      checks++;
      if (cmd_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_accept_%0d got=%b expected=1", k, cmd_ready);
      end else begin
        exp_q.push_back(ref_rsp(op, a, b));
      end
      @(negedge clk);
    end
    // Sixth command offered while full: must be refused.
    cmd_opcode = 4'h0;
    cmd_a      = 8'h11;
    cmd_b      = 8'h22;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b_full_%0d got=%b expected=0", k, cmd_ready);
      end
      checks++;
      if (rsp_valid !== 1'b1 || got_rsp() !== exp_q[0]) begin
        failures++;
        $display("FAIL b2b_hold_%0d got=valid%b rsp=%h expected=valid1 rsp=%h",
                 k, rsp_valid, got_rsp(), exp_q[0]);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(got, ok);
      checks++;
      if (!ok || got !== exp_q[k]) begin
        failures++;
        $display("FAIL b2b_rsp_%0d got=ok%0d rsp=%h expected=%h", k, ok, got, exp_q[k]);
      end
      $display("b2b rsp %0d: %h", k, got);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drained got=valid%b busy%b expected=valid0 busy0", rsp_valid, busy);
    end
  endtask

  task automatic test_random();
    logic [10:0] exp_q[$];
    logic [10:0] e;
    logic [10:0] prev;
    bit          hold_prev;
    int          n_rsp;
    hold_prev = 1'b0;
    prev      = '0;
    n_rsp     = 0;
    for (int i = 0; i < 460; i++) begin
      if (hold_prev) begin
        checks++;
        if (rsp_valid !== 1'b1 || got_rsp() !== prev) begin
          failures++;
          $display("FAIL rand_stable cyc=%0d got=valid%b rsp=%h expected=valid1 rsp=%h",
                   i, rsp_valid, got_rsp(), prev);
        end
      end
      if (i < 400) begin
        cmd_valid  = ($urandom_range(0, 2) != 0);
        cmd_opcode = 4'($urandom);
        cmd_a      = 8'($urandom);
        cmd_b      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        rsp_ready  = ($urandom_range(0, 2) != 0);
      end else begin
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
      end
      if (rsp_valid === 1'b1 && rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_unexpected cyc=%0d got=%h expected=no response", i, got_rsp());
        end else begin
          e = exp_q.pop_front();
          if (got_rsp() !== e) begin
            failures++;
            $display("FAIL rand_rsp cyc=%0d got=%h expected=%h", i, got_rsp(), e);
          end
          $display("rand rsp %0d: got=%h exp=%h", n_rsp, got_rsp(), e);
          n_rsp++;
        end
      end
      if (cmd_valid && cmd_ready === 1'b1) begin
        exp_q.push_back(ref_rsp(cmd_opcode, cmd_a, cmd_b));
      end
      hold_prev = (rsp_valid === 1'b1) && !rsp_ready;
      prev      = got_rsp();
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rand_drain got=pending%0d busy%b expected=pending0 busy0",
               exp_q.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] got;
    bit          ok;
    int          seen;
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cmd_valid  = 1'b1;
      cmd_opcode = 4'(k + 1);
      cmd_a      = 8'(8'h30 + k);
      cmd_b      = 8'h03;
      if (k == 4) rsp_ready = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    // Now issuing the second command with three more queued.
    checks++;
    if (busy !== 1'b1 || alu_opcode !== 4'h2) begin
      failures++;
      $display("FAIL midrst_pre got=busy%b op=%h expected=busy1 op=2", busy, alu_opcode);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0 ||
        {alu_opcode, alu_a, alu_b} !== '0) begin
      failures++;
      $display("FAIL midrst_async got=valid%b busy%b ready%b alu=%h expected=all 0",
               rsp_valid, busy, cmd_ready, {alu_opcode, alu_a, alu_b});
    end
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    seen      = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen++;
    end
    rsp_ready = 1'b0;
    checks++;
    if (seen != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_stale got=rsp_seen%0d busy%b expected=0 0", seen, busy);
    end
    send_cmd(4'h3, 8'h64, 8'h05);
    wait_rsp(got, ok);
    checks++;
    if (!ok || got !== ref_rsp(4'h3, 8'h64, 8'h05)) begin
      failures++;
      $display("FAIL midrst_fresh got=ok%0d rsp=%h expected=%h",
               ok, got, ref_rsp(4'h3, 8'h64, 8'h05));
    end
    $display("reset_mid: fresh rsp=%h", got);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
